// File: rtl/orbit_integrator.sv
// Per-frame fixed-point orbital integrator.
//
// On each accepted frame_tick, runs one semi-implicit Euler step of inverse-square gravity
// toward a fixed planet at (CX, CY). Position and velocity are signed Q16.8. The step uses a
// one-bit-per-cycle integer square root and a 32-cycle restoring divider, so each step has a
// fixed latency of 48 cycles.
//
// Ports:
//   clock_50    in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per frame; starts a step when idle
//   restart     in   synchronous one-cycle pulse; reloads the initial state
//   pos_x/pos_y out  ship position in integer pixels
//   out_valid   out  one-cycle strobe when pos_x/pos_y were just updated
//   busy        out  a step is in flight
//   crashed     out  sticky: radius fell below RMIN
//   escaped     out  sticky: position left the screen
//   overrun     out  sticky: a frame_tick arrived while busy and was dropped
module orbit_integrator #(
  parameter int CX    = 320,
  parameter int CY    = 240,
  parameter int GM    = 2000,
  parameter int X0    = 220,
  parameter int Y0    = 240,
  parameter int VX0   = 0,
  parameter int VY0   = 1145,
  parameter int RMIN  = 8,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       restart,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       out_valid,
  output logic       busy,
  output logic       crashed,
  output logic       escaped,
  output logic       overrun
);

  localparam logic signed [23:0] PxInit  = 24'(X0 * 256);
  localparam logic signed [23:0] PyInit  = 24'(Y0 * 256);
  localparam logic signed [23:0] VxInit  = 24'(VX0);
  localparam logic signed [23:0] VyInit  = 24'(VY0);
  localparam logic [9:0]         PosXInit = 10'(X0);
  localparam logic [9:0]         PosYInit = 10'(Y0);
  localparam logic [31:0]        DivNum  = 32'(GM) << 16;

  typedef enum logic [2:0] {
    StIdle, StSqr, StSqrt, StCube, StDiv, StAcc, StUpd, StHalt
  } state_e;

  state_e             state_q, state_d;
  logic signed [23:0] px_q, px_d, py_q, py_d;
  logic signed [23:0] vx_q, vx_d, vy_q, vy_d;
  logic signed [23:0] ax_q, ax_d, ay_q, ay_d;
  logic signed [16:0] dx_q, dx_d, dy_q, dy_d;
  logic [21:0]        r2_q, r2_d;
  logic [10:0]        root_q, root_d;
  logic [3:0]         bit_q, bit_d;
  logic [32:0]        r3_q, r3_d;
  logic [33:0]        rem_q, rem_d;
  logic [31:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic               out_valid_q, out_valid_d;
  logic               crashed_q, crashed_d;
  logic               escaped_q, escaped_d;
  logic               overrun_q, overrun_d;

  // Saturate a wide signed value to signed 24-bit.
  function automatic logic signed [23:0] sat24(input logic signed [41:0] v);
    if (v > 42'sd8388607) begin
      return 24'sh7FFFFF;
    end else if (v < -42'sd8388608) begin
      return 24'sh800000;
    end else begin
      return v[23:0];
    end
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------------------------
  logic signed [15:0] ix, iy;
  logic signed [16:0] dx_calc, dy_calc;
  assign ix      = px_q[23:8];
  assign iy      = py_q[23:8];
  assign dx_calc = {ix[15], ix} - 17'(CX);
  assign dy_calc = {iy[15], iy} - 17'(CY);

  logic signed [33:0] dx_sq, dy_sq, r2_full;
  assign dx_sq   = dx_q * dx_q;
  assign dy_sq   = dy_q * dy_q;
  assign r2_full = dx_sq + dy_sq;

  // Bit-serial square root: try setting the current bit, keep it if trial^2 still fits.
  logic [10:0] trial, root_next;
  logic [21:0] trial_sq;
  assign trial     = root_q | (11'd1 << bit_q);
  assign trial_sq  = 22'(trial) * 22'(trial);
  assign root_next = (trial_sq <= r2_q) ? trial : root_q;

  logic [32:0] r3_calc;
  assign r3_calc = 33'(r2_q) * 33'(root_q);

  // Restoring divider: quo_q shifts the dividend out from the top and the quotient in at the
  // bottom, so after 32 steps it holds floor(DivNum / r3).
  logic [33:0] rem_shift, rem_sub;
  logic        rem_ge;
  assign rem_shift = {rem_q[32:0], quo_q[31]};
  assign rem_ge    = rem_shift >= {1'b0, r3_q};
  assign rem_sub   = rem_shift - {1'b0, r3_q};

  logic [23:0] k;
  assign k = (|quo_q[31:24]) ? 24'hFFFFFF : quo_q[23:0];

  logic signed [41:0] k_ext, dx_ext, dy_ext, prod_x, prod_y;
  assign k_ext  = {18'd0, k};
  assign dx_ext = {{25{dx_q[16]}}, dx_q};
  assign dy_ext = {{25{dy_q[16]}}, dy_q};
  assign prod_x = -(dx_ext * k_ext) >>> 8;
  assign prod_y = -(dy_ext * k_ext) >>> 8;

  logic signed [41:0] vx_sum, vy_sum;
  logic signed [23:0] vx_new, vy_new, px_new, py_new;
  logic [15:0]        ix_new, iy_new;
  logic               on_screen;
  assign vx_sum    = {{18{vx_q[23]}}, vx_q} + {{18{ax_q[23]}}, ax_q};
  assign vy_sum    = {{18{vy_q[23]}}, vy_q} + {{18{ay_q[23]}}, ay_q};
  assign vx_new    = sat24(vx_sum);
  assign vy_new    = sat24(vy_sum);
  assign px_new    = px_q + vx_new;
  assign py_new    = py_q + vy_new;
  assign ix_new    = px_new[23:8];
  assign iy_new    = py_new[23:8];
  assign on_screen = !ix_new[15] && (ix_new < 16'(H_RES)) &&
                     !iy_new[15] && (iy_new < 16'(V_RES));

  // rem_q never reaches bit 33 and the screen bounds keep r2 within 22 bits.
  logic unused_bits;
  assign unused_bits = ^{rem_q[33], r2_full[33:22]};

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    r2_d        = r2_q;
    root_d      = root_q;
    bit_d       = bit_q;
    r3_d        = r3_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    out_valid_d = 1'b0;
    crashed_d   = crashed_q;
    escaped_d   = escaped_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          dx_d    = dx_calc;
          dy_d    = dy_calc;
          state_d = StSqr;
        end
      end
      StSqr: begin
        r2_d    = r2_full[21:0];
        root_d  = '0;
        bit_d   = 4'd10;
        state_d = StSqrt;
      end
      StSqrt: begin
        root_d = root_next;
        bit_d  = bit_q - 4'd1;
        if (bit_q == 4'd0) begin
          if (root_next < 11'(RMIN)) begin
            crashed_d = 1'b1;
            state_d   = StHalt;
          end else begin
            state_d = StCube;
          end
        end
      end
      StCube: begin
        r3_d    = r3_calc;
        rem_d   = '0;
        quo_d   = DivNum;
        cnt_d   = '0;
        state_d = StDiv;
      end
      StDiv: begin
        rem_d = rem_ge ? rem_sub : rem_shift;
        quo_d = {quo_q[30:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StAcc;
        end
      end
      StAcc: begin
        ax_d    = sat24(prod_x);
        ay_d    = sat24(prod_y);
        state_d = StUpd;
      end
      StUpd: begin
        vx_d = vx_new;
        vy_d = vy_new;
        px_d = px_new;
        py_d = py_new;
        if (on_screen) begin
          pos_x_d     = ix_new[9:0];
          pos_y_d     = iy_new[9:0];
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          escaped_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A tick while a step is in flight is dropped; HALT ignores ticks altogether.
    if (frame_tick && state_q != StIdle && state_q != StHalt) begin
      overrun_d = 1'b1;
    end

    // Restart wins over everything, including a coincident frame_tick.
    if (restart) begin
      state_d     = StIdle;
      px_d        = PxInit;
      py_d        = PyInit;
      vx_d        = VxInit;
      vy_d        = VyInit;
      pos_x_d     = PosXInit;
      pos_y_d     = PosYInit;
      out_valid_d = 1'b0;
      crashed_d   = 1'b0;
      escaped_d   = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      px_q        <= PxInit;
      py_q        <= PyInit;
      vx_q        <= VxInit;
      vy_q        <= VyInit;
      ax_q        <= '0;
      ay_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      r2_q        <= '0;
      root_q      <= '0;
      bit_q       <= '0;
      r3_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      pos_x_q     <= PosXInit;
      pos_y_q     <= PosYInit;
      out_valid_q <= 1'b0;
      crashed_q   <= 1'b0;
      escaped_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      r2_q        <= r2_d;
      root_q      <= root_d;
      bit_q       <= bit_d;
      r3_q        <= r3_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      out_valid_q <= out_valid_d;
      crashed_q   <= crashed_d;
      escaped_q   <= escaped_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle) && (state_q != StHalt);
  assign crashed   = crashed_q;
  assign escaped   = escaped_q;
  assign overrun   = overrun_q;

endmodule
